imem_loader: RTL

//   Boot-time program loader: writer side of the instruction memory that the IFU reads.
//   - Accepts a byte stream over valid/ready and packs it into 32-bit instruction words.
//   - Writes the words to consecutive instruction-memory word addresses.
//   - Holds the single-cycle core in reset until the whole program image is written.

---
 rtl/imem_loader_pkg.sv | 20 ++
 rtl/imem_loader_byte_packer.sv | 28 ++
 rtl/imem_loader.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM state encoding and stream count width.
// The CHECK state only exists when LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

    localparam int unsigned COUNT_W = 16;

    typedef enum logic [2:0] {
        StCntLo,
        StCntHi,
        StWord,
        StWrite,
`ifdef LOADER_CHECKSUM_EN
        StCheck,
`endif
        StFinish,
        StDone,
        StError
    } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs four little-endian stream bytes into a 32-bit word.
// word_ready pulses combinationally with the accepted 4th byte; word is valid in that cycle.
module imem_loader_byte_packer (
    input  logic        clk,
    input  logic        reset,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_ready,
    output logic [31:0] word
);

    logic [1:0]  cnt_q;
    logic [23:0] shift_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= 2'd0;
            shift_q <= 24'd0;
        end else if (byte_valid) begin
            cnt_q   <= cnt_q + 2'd1;
            shift_q <= {byte_data, shift_q[23:8]};
        end
    end

    assign word_ready = byte_valid && (cnt_q == 2'd3);
    assign word       = {byte_data, shift_q};

endmodule

// File: rtl/imem_loader.sv
// Boot loader: packs a counted byte stream into instruction words, writes them to imem and
// releases the core reset when done. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  cpu_reset,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned MAX_WORDS = (32'd1 << ADDR_WIDTH) - BASE_ADDR;
    localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

    loader_state_e         state_q, state_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic [COUNT_W-1:0]    words_q, words_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [COUNT_W-1:0]    n_full;
    logic                  pack_valid;
    logic                  word_ready;
    logic [31:0]           packed_word;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    assign pack_valid = in_valid && (state_q == StWord);
    assign n_full     = {in_data, count_q[7:0]};

    imem_loader_byte_packer u_packer (
        .clk        (clk),
        .reset      (reset),
        .byte_valid (pack_valid),
        .byte_data  (in_data),
        .word_ready (word_ready),
        .word       (packed_word)
    );

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        words_d   = words_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        in_ready  = 1'b0;
        mem_we    = 1'b0;
        cpu_reset = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
`ifdef LOADER_CHECKSUM_EN
        csum_d    = csum_q;
`endif
        unique case (state_q)
            StCntLo: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d[7:0] = in_data;
                    state_d      = StCntHi;
                end
            end
            StCntHi: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    count_d = n_full;
                    if (n_full == '0) begin
`ifdef LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StFinish;
`endif
                    end else if (32'(n_full) > MAX_WORDS) begin
                        state_d = StError;
                    end else begin
                        state_d = StWord;
                    end
                end
            end
            StWord: begin
                in_ready = 1'b1;
`ifdef LOADER_CHECKSUM_EN
                if (in_valid) csum_d = csum_q ^ in_data;
`endif
                if (word_ready) begin
                    wdata_d = packed_word;
                    state_d = StWrite;
                end
            end
            StWrite: begin
                mem_we  = 1'b1;
                addr_d  = addr_q + ADDR_WIDTH'(1);
                words_d = words_q + COUNT_W'(1);
                if (words_q == count_q - COUNT_W'(1)) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = StFinish;
`endif
                end else begin
                    state_d = StWord;
                end
            end
`ifdef LOADER_CHECKSUM_EN
            StCheck: begin
                in_ready = 1'b1;
                if (in_valid) state_d = (in_data == csum_q) ? StFinish : StError;
            end
`endif
            StFinish: state_d = StDone;
            StDone: begin
                done      = 1'b1;
                cpu_reset = 1'b0;
            end
            StError: error = 1'b1;
            default: state_d = StError;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StCntLo;
            count_q <= '0;
            words_q <= '0;
            addr_q  <= BASE;
            wdata_q <= 32'd0;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            words_q <= words_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

endmodule
